// File: rtl/des_key_sched.sv
`default_nettype none
// ============================================================================
//  Module   : des_key_sched
//  Purpose  : Sequential DES key schedule; emits the 16 round subkeys one per
//             handshake in encrypt (K1..K16) or decrypt (K16..K1) order.
//  Revision : 1.0  initial release
// ============================================================================
module des_key_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key_in,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round,
    output logic        busy,
    output logic        done
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Bit i set means round i's shift is one position; all others shift by two.
    localparam logic [15:0] SINGLE_SHIFT = 16'b1000_0001_0000_0011;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int j = 0; j < 56; j++) begin
            r[55-j] = k[64-PC1_TAB[j]];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int j = 0; j < 48; j++) begin
            r[47-j] = cd[56-PC2_TAB[j]];
        end
        return r;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic by_two);
        return by_two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic by_two);
        return by_two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    logic [0:0]  state_q, state_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic [3:0]  round_q, round_d;
    logic        mode_q, mode_d;
    logic        done_q, done_d;

    logic [55:0] w_cd_load;
    logic [3:0]  w_round_next;
    logic        w_left_two;
    logic        w_right_two;
    logic        unused_parity;

    assign w_cd_load     = pc1(key_in);
    assign w_round_next  = round_q + 4'd1;
    assign w_left_two    = ~SINGLE_SHIFT[w_round_next];
    assign w_right_two   = ~SINGLE_SHIFT[4'd15 - round_q];
    assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                             key_in[24], key_in[16], key_in[8],  key_in[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Decrypt starts from C0/D0, which already equals C16/D16.
                    if (decrypt) begin
                        c_d = w_cd_load[55:28];
                        d_d = w_cd_load[27:0];
                    end else begin
                        c_d = rotl28(w_cd_load[55:28], 1'b0);
                        d_d = rotl28(w_cd_load[27:0], 1'b0);
                    end
                    mode_d  = decrypt;
                    round_d = 4'd0;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (subkey_ready) begin
                    if (round_q == 4'd15) begin
                        state_d = ST_IDLE;
                        round_d = 4'd0;
                        done_d  = 1'b1;
                    end else begin
                        round_d = w_round_next;
                        if (mode_q) begin
                            c_d = rotr28(c_q, w_right_two);
                            d_d = rotr28(d_q, w_right_two);
                        end else begin
                            c_d = rotl28(c_q, w_left_two);
                            d_d = rotl28(d_q, w_left_two);
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        subkey_valid = (state_q == ST_EMIT);
        busy         = (state_q == ST_EMIT);
        subkey       = pc2({c_q, d_q});
        round        = round_q;
        done         = done_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_des_key_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_des_key_sched
//  Purpose  : Self-checking bench for des_key_sched against a key-schedule model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_des_key_sched;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B = 64'h123456789ABCDEF0;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        decrypt = 1'b0;
    logic [63:0] key_in = '0;
    logic        subkey_ready = 1'b1;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic [3:0]  round;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_err    = 0;

    des_key_sched dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .decrypt      (decrypt),
        .key_in       (key_in),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round        (round),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Ki = PC-2 of PC-1 halves each rotated left by the cumulative shift count.
    function automatic logic [15:0][47:0] model_ks(input logic [63:0] key);
        logic [15:0][47:0] ks;
        logic [55:0] cd0;
        logic [55:0] cdi;
        int tot;
        ks  = '0;
        cd0 = '0;
        cdi = '0;
        tot = 0;
        for (int j = 0; j < 56; j++) cd0[55-j] = key[64-PC1[j]];
        for (int i = 0; i < 16; i++) begin
            tot += SHIFTS[i];
            for (int b = 0; b < 28; b++) begin
                cdi[55-b] = cd0[55-((b + tot) % 28)];
                cdi[27-b] = cd0[27-((b + tot) % 28)];
            end
            for (int j = 0; j < 48; j++) ks[i][47-j] = cdi[56-PC2[j]];
        end
        return ks;
    endfunction

    logic              m_active = 1'b0;
    logic [3:0]        m_idx    = '0;
    logic              m_dec    = 1'b0;
    logic              m_done   = 1'b0;
    logic [15:0][47:0] m_ks     = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
            m_idx    <= '0;
            m_done   <= 1'b0;
        end else if (!m_active) begin
            m_done <= 1'b0;
            if (start) begin
                m_active <= 1'b1;
                m_idx    <= '0;
                m_dec    <= decrypt;
                m_ks     <= model_ks(key_in);
            end
        end else begin
            m_done <= 1'b0;
            if (subkey_ready) begin
                if (m_idx == 4'd15) begin
                    m_active <= 1'b0;
                    m_idx    <= '0;
                    m_done   <= 1'b1;
                end else begin
                    m_idx <= m_idx + 4'd1;
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #2;
        check("cyc_valid", subkey_valid, m_active);
        check("cyc_busy", busy, m_active);
        check("cyc_round", round, m_idx);
        check("cyc_done", done, m_done);
        if (m_active)
            check("cyc_subkey", subkey, m_dec ? m_ks[15-m_idx] : m_ks[m_idx]);
    end

    task automatic do_start(input logic [63:0] key, input logic dec);
        @(negedge clk);
        key_in  = key;
        decrypt = dec;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic run_collect(input logic [63:0] key, input logic dec,
                               output logic [15:0][47:0] seq);
        seq = '0;
        do_start(key, dec);
        for (int i = 0; i < 16; i++) begin
            seq[i] = subkey;
            check("run_busy", busy, 1'b1);
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40 && busy; k++) @(negedge clk);
        check("idle_timeout", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0][47:0] mk;
        logic [15:0][47:0] enc;
        logic [15:0][47:0] dec;
        logic [15:0][47:0] seqb;
        logic [47:0] held;
        int diffs;

        mk = model_ks(KEY_A);
        check("model_k1", mk[0], 48'h1B02EFFC7072);
        check("model_k2", mk[1], 48'h79AED9DBC9E5);
        check("model_k16", mk[15], 48'hCB3D8B0E17F5);

        repeat (3) @(negedge clk);
        check("rst_valid", subkey_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_round", round, 4'd0);
        check("rst_subkey", subkey, 48'h0);
        rst = 1'b0;

        // Encrypt run
        run_collect(KEY_A, 1'b0, enc);
        check("enc_r0", enc[0], 48'h1B02EFFC7072);
        check("enc_r1", enc[1], 48'h79AED9DBC9E5);
        check("enc_r15", enc[15], 48'hCB3D8B0E17F5);
        check("enc_done", done, 1'b1);
        check("enc_done_busy", busy, 1'b0);
        @(negedge clk);
        check("enc_done_once", done, 1'b0);

        // Decrypt run
        run_collect(KEY_A, 1'b1, dec);
        check("dec_r0", dec[0], 48'hCB3D8B0E17F5);
        check("dec_r15", dec[15], 48'h1B02EFFC7072);
        for (int i = 0; i < 16; i++) check("dec_reverse", dec[i], enc[15-i]);
        check("dec_done", done, 1'b1);

        // Backpressure at round 3
        do_start(KEY_A, 1'b0);
        repeat (3) @(negedge clk);
        check("bp_round3", round, 4'd3);
        subkey_ready = 1'b0;
        held = subkey;
        for (int i = 0; i < 5; i++) begin
            start   = ~start;
            decrypt = ~decrypt;
            key_in  = ~key_in;
            @(negedge clk);
            check("bp_subkey", subkey, held);
            check("bp_round", round, 4'd3);
            check("bp_valid", subkey_valid, 1'b1);
        end
        start        = 1'b0;
        subkey_ready = 1'b1;
        @(negedge clk);
        check("bp_release_round", round, 4'd4);
        check("bp_release_subkey", subkey, enc[4]);
        wait_idle();

        // Reset mid-schedule at round 7
        do_start(KEY_A, 1'b0);
        repeat (7) @(negedge clk);
        check("rs_round7", round, 4'd7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rs_valid", subkey_valid, 1'b0);
        check("rs_busy", busy, 1'b0);
        check("rs_round", round, 4'd0);
        check("rs_subkey", subkey, 48'h0);
        check("rs_done", done, 1'b0);
        @(negedge clk);
        check("rs_no_done", done, 1'b0);
        do_start(KEY_A, 1'b1);
        check("rs_restart_round", round, 4'd0);
        check("rs_restart_subkey", subkey, 48'hCB3D8B0E17F5);
        wait_idle();

        // Back-to-back start in the done cycle
        do_start(KEY_A, 1'b0);
        repeat (16) @(negedge clk);
        check("b2b_done", done, 1'b1);
        key_in  = 64'h0;
        decrypt = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_valid", subkey_valid, 1'b1);
        check("b2b_round", round, 4'd0);
        for (int i = 0; i < 16; i++) begin
            check("b2b_zero_subkey", subkey, 48'h0);
            @(negedge clk);
        end
        check("b2b_done2", done, 1'b1);

        // Parity insensitivity
        run_collect(KEY_B, 1'b0, seqb);
        diffs = 0;
        for (int i = 0; i < 16; i++) if (seqb[i] !== enc[i]) diffs++;
        check("parity_enc", diffs, 0);
        run_collect(KEY_B, 1'b1, seqb);
        diffs = 0;
        for (int i = 0; i < 16; i++) if (seqb[i] !== dec[i]) diffs++;
        check("parity_dec", diffs, 0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/des_key_sched.md
# des_key_sched

Sequential DES key schedule. Loads a 64-bit key and emits the 16 round subkeys (48 bits each) one at a time over a valid/ready handshake. Subkeys come out in encrypt order (K1..K16, left rotations) or decrypt order (K16..K1, right rotations). It feeds the round datapath that drives the s_box1..s_box8 substitution stage, so the same round hardware can encrypt and decrypt.

## Interface
Parameters: none. DES bit numbering: DES bit 1 = MSB of each bus.
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  load key_in/decrypt and begin a schedule; honoured only when busy=0
- decrypt  in  1  0 = emit K1..K16; 1 = emit K16..K1; sampled with start
- key_in  in  64  DES key; parity bits 8,16,..,64 ignored by PC-1
- subkey  out  48  current subkey, PC-2 of internal C/D registers
- subkey_valid  out  1  subkey and round are valid
- subkey_ready  in  1  consumer accepts subkey this cycle when valid&ready
- round  out  4  index of current output, 0..15 in emission order
- busy  out  1  schedule in progress
- done  out  1  one-cycle pulse after the 16th subkey is accepted

## Operation
- State: c[27:0], d[27:0], round counter, mode bit, FSM {IDLE, EMIT}.
- IDLE: subkey_valid=0, busy=0. When start=1, load {c,d} = PC-1(key_in) and apply the first step:
  - encrypt: rotate c and d left by 1.
  - decrypt: no rotation. C0/D0 equals C16/D16 because the total shift over 16 rounds is 28.
  - On the same load: mode<=decrypt, round<=0, go to EMIT.
- EMIT: subkey_valid=1, busy=1, subkey=PC-2({c,d}) (combinational from registers).
- On valid&ready with round<15: round++, then rotate c and d:
  - encrypt: left by S[round+1].
  - decrypt: right by S[15-round].
  - S[0..15] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- On valid&ready with round==15: go to IDLE, done=1 for the next cycle, round<=0.
- Without ready, all of the following hold stable: subkey, round, subkey_valid, c and d.
- start during EMIT is ignored. decrypt and key_in are don't-care outside the start cycle.
- PC-1 and PC-2 are exactly the FIPS 46-3 tables. Rotations are circular within each 28-bit half and never cross between c and d.

## Timing
- Reset: state IDLE, c=d=0, round=0, mode=0, subkey_valid=0, busy=0, done=0. subkey=PC-2(0)=0.
- rst has priority over start and over the handshake. Reset mid-schedule aborts it: no done pulse, valid drops on the next edge.
- Latency: start sampled at edge N makes subkey_valid=1 with round 0 after edge N. The first subkey is available in the cycle after start.
- Throughput: one subkey per cycle with ready held high. The full schedule takes 16 cycles after the start cycle.
- done asserts in the cycle after the final handshake, with busy=0. A start in that same cycle is accepted, giving back-to-back schedules with one idle cycle.
- round always equals the number of handshakes completed in the current schedule.

## Test plan
- Encrypt, key 133457799BBCDFF1, ready=1.
  - round0 = 1B02EFFC7072.
  - round1 = 79AED9DBC9E5.
  - round15 = CB3D8B0E17F5.
  - done pulses exactly one cycle after the 16th accept; busy is high for exactly 16 cycles.
- Decrypt, same key, ready=1.
  - round0 = CB3D8B0E17F5; round15 = 1B02EFFC7072.
  - The full sequence is the exact reverse of the encrypt run.
- Backpressure: hold ready=0 for 5 cycles at round 3, toggle start and decrypt meanwhile.
  - subkey, round and valid stay frozen and start is ignored.
  - On release, round 4 follows.
- Reset at round 7: assert rst for one cycle.
  - Next cycle: valid=0, busy=0, round=0, subkey=0, no done pulse.
  - A following start restarts cleanly from round 0.
- Back-to-back: assert start in the done cycle with a different key (0000000000000000).
  - The second schedule begins the following cycle.
  - All 16 subkeys are 000000000000.
- Parity insensitivity: keys 133457799BBCDFF1 and 123456789ABCDEF0 differ only in parity bits.
  - Both produce identical 16-subkey sequences in both modes.
